rat_irq_ctrl: RTL and testbench
===============================

# rat_irq_ctrl

Priority interrupt controller for the RAT CPU: collects up to eight external interrupt sources and drives the CPU's single `INTERRUPT` input, a level signal that the CPU's interrupt flag gates. The block sits on the CPU I/O bus (`PORT_ID`, `OUT_PORT`, `IO_STRB`, `IN_PORT`). Firmware masks sources, reads pending status and the winning vector, and acknowledges and ends service with I/O writes.

## Interface
- `N_SRC`, default 8: number of sources, 1..8; unused bits read 0.
- `BASE_ID`, default 8'hE0: first of four consecutive port IDs; must be 4-aligned.
- `CLK` in 1: system clock; all state updates on the rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `IRQ` in N_SRC: source requests; a rising edge requests service.
- `PORT_ID` in 8: CPU port address.
- `OUT_PORT` in 8: CPU write data.
- `IO_STRB` in 1: one-cycle CPU write strobe.
- `INTERRUPT` out 1: request to the CPU.
- `IRQ_DOUT` out 8: read data for the `IN_PORT` mux; combinational from `PORT_ID`.
- `IRQ_SEL` out 1: high when `PORT_ID` is in BASE_ID..BASE_ID+3.

## Operation
- Port map:
  - BASE+0 is MASK, read/write; 1 enables the source.
  - BASE+1 is PENDING, read-only.
  - BASE+2 reads as VECTOR {5'b0, idx[2:0]}; a write to BASE+2 is ACK, and the write data is ignored.
  - BASE+3 write is EOI, data ignored; a read of BASE+3 returns {6'b0, state[1:0]}.
- A write is `IO_STRB`=1 with a matching `PORT_ID`. Writes to read-only addresses are ignored.
- Edge detect: `pending[i]` sets when the sampled `IRQ[i]`=1 and the previous sample was 0. Masked sources still latch pending.
- FSM states: IDLE=0, REQ=1, SERVICE=2. Encoding 3 is illegal and goes to IDLE.
  - IDLE → REQ when (pending & mask) != 0. On the same edge, `vec` latches the lowest set index of (pending & mask), so bit 0 has highest priority.
  - REQ → SERVICE on an ACK write. On the same edge, `pending[vec]` clears.
  - SERVICE → IDLE on an EOI write.
  - ACK outside REQ and EOI outside SERVICE are ignored.
- `INTERRUPT` = (state == REQ), decoded from the state register, so it is glitch-free.
- `vec` is frozen in REQ and SERVICE. No nesting: new requests wait in pending until the FSM returns to IDLE.
- A MASK write that clears the bit for `vec` while in REQ does not cancel REQ. The ISR must still ACK.
- Simultaneous set and clear on the same pending bit (new edge during the ACK cycle): set wins.
- Reset values (asynchronous, effective immediately while `RESET_N`=0):
  - state=IDLE, mask=8'h00, pending=0, vec=0.
  - edge/sync registers = 0.
  - `INTERRUPT`=0.
- An IRQ held high through reset release counts as a rising edge on the first sample.

## Timing
- Without IRQ_SYNC_EN: the IRQ rising edge sampled at clock edge k → pending visible after edge k → FSM enters REQ after edge k+1 (if unmasked) → `INTERRUPT` high after k+1.
- With IRQ_SYNC_EN: add 2 cycles.
- ACK/EOI take effect on the edge where `IO_STRB` is sampled high. `INTERRUPT` falls after the ACK edge.
- Back-to-back: after EOI, IDLE lasts a minimum of 1 cycle before the next REQ.
- `IRQ_DOUT` is valid in the same cycle as `PORT_ID`, zero latency, and is 0 when `IRQ_SEL`=0.
- IRQ pulses shorter than 1 CLK period may be missed when the synchronizer is compiled out.

## Configuration
- `RAT_IRQ_SYNC_EN` defined: each IRQ bit passes through a 2-flop synchronizer before edge detect, so asynchronous sources are safe. Latency is +2 cycles.
- Not defined: IRQ is sampled directly by the edge-detect flop. Sources must be synchronous to `CLK`.

## Test plan
- Reset: assert `RESET_N`=0 mid-REQ with mask=8'hFF and pending=8'h05 → immediately `INTERRUPT`=0; after release, PENDING reads 8'h00 and MASK reads 8'h00.
- Basic: write MASK=8'h08, pulse IRQ[3] → `INTERRUPT` high at the specified cycle and VECTOR reads 8'h03. ACK → `INTERRUPT` low and PENDING reads 8'h00. EOI → state reads 0.
- Priority: with mask=8'hFF, raise IRQ[6] and IRQ[2] in the same cycle → VECTOR=8'h02. ACK, EOI → second REQ with VECTOR=8'h06.
- Masking: with mask=8'h00, pulse IRQ[1] → `INTERRUPT` stays 0 and PENDING=8'h02. Write mask=8'h02 → `INTERRUPT` rises 1 cycle after the write edge.
- Collision: new IRQ[4] edge in the ACK cycle for vec=4 → after ACK, PENDING bit 4 = 1. After EOI, REQ is re-entered with vec=4.
- Protocol misuse: EOI in REQ and ACK in IDLE → no state change. A write to BASE+1 → PENDING unchanged. `PORT_ID`=8'hE4 → `IRQ_SEL`=0 and `IRQ_DOUT`=0.

Source files
------------

// File: rtl/rat_irq_ctrl.sv
// rat_irq_ctrl - priority interrupt controller for the RAT CPU I/O bus.
//
// Collects up to eight edge-triggered sources, arbitrates by lowest index
// and raises INTERRUPT until firmware acknowledges. Four consecutive port
// IDs from BASE_ID: MASK (rw), PENDING (ro), VECTOR / ACK, STATE / EOI.
//
// Compile-time option: define RAT_IRQ_SYNC_EN to put a 2-flop synchronizer
// on every IRQ bit ahead of edge detection (asynchronous sources, +2 cycles).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no request outstanding; watching (pending & mask)
// ST_REQ     | vec latched, INTERRUPT asserted, waiting for ACK write
// ST_SERVICE | ISR running, pending[vec] cleared, waiting for EOI write

module rat_irq_ctrl #(
   parameter int          N_SRC   = 8,
   parameter logic [7:0]  BASE_ID = 8'hE0
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [N_SRC-1:0] IRQ,
   input  logic [7:0]       PORT_ID,
   input  logic [7:0]       OUT_PORT,
   input  logic             IO_STRB,
   output logic             INTERRUPT,
   output logic [7:0]       IRQ_DOUT,
   output logic             IRQ_SEL
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } state_t;

   // Bits above N_SRC never exist, so they are forced to zero on every path.
   localparam logic [8:0] SRC_MASK9 = (9'd1 << N_SRC) - 9'd1;
   localparam logic [7:0] SRC_MASK  = SRC_MASK9[7:0];

   state_t       r_state;
   state_t       w_state_nxt;
   logic [7:0]   r_mask;
   logic [7:0]   r_pending;
   logic [2:0]   r_vec;
   logic [7:0]   r_irq_prev;

   logic [7:0]   w_irq8;
   logic [7:0]   w_irq_smp;
   logic [7:0]   w_rise;
   logic [7:0]   w_req;
   logic [2:0]   w_lowest;
   logic [7:0]   w_ack_clr;
   logic         w_wr;
   logic         w_wr_mask;
   logic         w_ack;
   logic         w_eoi;
   logic         w_load_vec;

   // Zero-extend the source vector to the full 8-bit register width.
   always_comb begin
      w_irq8            = '0;
      w_irq8[N_SRC-1:0] = IRQ;
   end

`ifdef RAT_IRQ_SYNC_EN
   logic [7:0] r_sync1;
   logic [7:0] r_sync2;

   // Two-flop synchronizer per source bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_irq8;
         r_sync2 <= r_sync1;
      end
   end

   assign w_irq_smp = r_sync2;
`else
   assign w_irq_smp = w_irq8;
`endif

   // Previous sample for edge detection; cleared in reset so a source held
   // high across reset release is seen as a fresh edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_irq_prev <= '0;
      else          r_irq_prev <= w_irq_smp;
   end

   assign w_rise = w_irq_smp & ~r_irq_prev & SRC_MASK;

   // Bus decode: port window is the 4-aligned block at BASE_ID.
   assign IRQ_SEL   = (PORT_ID[7:2] == BASE_ID[7:2]);
   assign w_wr      = IO_STRB & IRQ_SEL;
   assign w_wr_mask = w_wr & (PORT_ID[1:0] == 2'd0);
   assign w_ack     = w_wr & (PORT_ID[1:0] == 2'd2);
   assign w_eoi     = w_wr & (PORT_ID[1:0] == 2'd3);

   // Lowest enabled pending index wins (bit 0 highest priority).
   always_comb begin
      w_req    = r_pending & r_mask;
      w_lowest = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_req[i]) w_lowest = 3'(i);
      end
   end

   // Next-state decode; ACK outside REQ and EOI outside SERVICE fall through.
   always_comb begin
      w_state_nxt = r_state;
      w_load_vec  = 1'b0;
      w_ack_clr   = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_req != 8'd0) begin
               w_state_nxt = ST_REQ;
               w_load_vec  = 1'b1;
            end
         end
         ST_REQ: begin
            if (w_ack) begin
               w_state_nxt = ST_SERVICE;
               w_ack_clr   = 8'd1 << r_vec;
            end
         end
         ST_SERVICE: begin
            if (w_eoi) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Vector latches only on entry to REQ, so it stays frozen through service.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)        r_vec <= 3'd0;
      else if (w_load_vec) r_vec <= w_lowest;
   end

   // Mask register; clearing the active source's bit does not cancel REQ.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N)       r_mask <= 8'h00;
      else if (w_wr_mask) r_mask <= OUT_PORT & SRC_MASK;
   end

   // Pending latches edges even when masked; a new edge beats the ACK clear.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) r_pending <= 8'h00;
      else          r_pending <= (r_pending & ~w_ack_clr) | w_rise;
   end

   assign INTERRUPT = (r_state == ST_REQ);

   // Zero-latency read mux for the CPU IN_PORT.
   always_comb begin
      IRQ_DOUT = 8'h00;
      if (IRQ_SEL) begin
         case (PORT_ID[1:0])
            2'd0:    IRQ_DOUT = r_mask;
            2'd1:    IRQ_DOUT = r_pending;
            2'd2:    IRQ_DOUT = {5'b0, r_vec};
            default: IRQ_DOUT = {6'b0, r_state};
         endcase
      end
   end

endmodule

// File: tb/tb_rat_irq_ctrl.sv
// Bench for rat_irq_ctrl: directed scenarios plus a randomized run, all
// checked against a transaction-level model kept in this file.
module tb_rat_irq_ctrl;

   localparam logic [7:0] BASE = 8'hE0;
`ifdef RAT_IRQ_SYNC_EN
   localparam int SYNC_LAT = 2;
`else
   localparam int SYNC_LAT = 0;
`endif

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic [7:0] IRQ = 8'h00;
   logic [7:0] PORT_ID = 8'h00;
   logic [7:0] OUT_PORT = 8'h00;
   logic       IO_STRB = 1'b0;
   logic       INTERRUPT;
   logic [7:0] IRQ_DOUT;
   logic       IRQ_SEL;

   int n_cmp = 0;
   int n_err = 0;

   // model: phase 0 idle, 1 waiting for ack, 2 in service
   bit [7:0] m_mask, m_pend, m_prev, m_s1, m_s2;
   int       m_phase, m_vec;

   rat_irq_ctrl #(.N_SRC(8), .BASE_ID(BASE)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .IRQ(IRQ), .PORT_ID(PORT_ID),
      .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INTERRUPT(INTERRUPT),
      .IRQ_DOUT(IRQ_DOUT), .IRQ_SEL(IRQ_SEL)
   );

   always #5 CLK = ~CLK;

   task automatic m_reset();
      m_mask = 0; m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0;
      m_phase = 0; m_vec = 0;
   endtask

   function automatic int m_lowest(bit [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic bit [7:0] m_read(bit [7:0] port);
      int off;
      off = int'(port) - int'(BASE);
      case (off)
         0: return m_mask;
         1: return m_pend;
         2: return 8'(m_vec);
         3: return 8'(m_phase);
         default: return 8'h00;
      endcase
   endfunction

   // Advance the model with the inputs the DUT is about to sample, then clock.
   task automatic step();
      bit [7:0] samp, rise, clr;
      int off;
      bit wr;
`ifdef RAT_IRQ_SYNC_EN
      samp = m_s2; m_s2 = m_s1; m_s1 = IRQ;
`else
      samp = IRQ;
`endif
      rise   = samp & ~m_prev;
      m_prev = samp;
      off    = int'(PORT_ID) - int'(BASE);
      wr     = IO_STRB && off >= 0 && off <= 3;
      clr    = 0;
      if (m_phase == 0) begin
         if ((m_pend & m_mask) != 0) begin
            m_phase = 1;
            m_vec   = m_lowest(m_pend & m_mask);
         end
      end else if (m_phase == 1) begin
         if (wr && off == 2) begin
            m_phase = 2;
            clr[m_vec] = 1'b1;
         end
      end else if (wr && off == 3) begin
         m_phase = 0;
      end
      if (wr && off == 0) m_mask = OUT_PORT;
      m_pend = (m_pend & ~clr) | rise;
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [7:0] irq, input logic [7:0] port,
                        input logic [7:0] data, input logic strb);
      IRQ = irq; PORT_ID = port; OUT_PORT = data; IO_STRB = strb;
   endtask

   task automatic peek(input logic [7:0] port);
      IO_STRB = 1'b0; PORT_ID = port;
      #1;
   endtask

   task automatic test_reset();
      #3;
      n_cmp++;
      if (INTERRUPT !== 1'b0) begin n_err++; $display("FAIL reset_int: got %b want 0", INTERRUPT); end
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      m_reset();
      for (int p = 0; p < 4; p++) begin
         peek(BASE + 8'(p));
         n_cmp++;
         if (IRQ_DOUT !== 8'h00) begin n_err++; $display("FAIL reset_reg%0d: got %h want 00", p, IRQ_DOUT); end
      end
   endtask

   task automatic test_reset_mid_req();
      drive(8'h00, BASE, 8'hFF, 1'b1); step();
      drive(8'h05, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 1) step();
      peek(BASE + 8'd1);
      n_cmp++;
      if (INTERRUPT !== 1'b1 || IRQ_DOUT !== 8'h05) begin
         n_err++; $display("FAIL rst_setup: int %b pend %h want 1 05", INTERRUPT, IRQ_DOUT);
      end
      RESET_N = 1'b0;
      #1;
      m_reset();
      n_cmp++;
      if (INTERRUPT !== 1'b0) begin n_err++; $display("FAIL rst_async: got %b want 0", INTERRUPT); end
      @(posedge CLK); #1;
      RESET_N = 1'b1;
      peek(BASE + 8'd1);
      n_cmp++;
      if (IRQ_DOUT !== 8'h00) begin n_err++; $display("FAIL rst_pend: got %h want 00", IRQ_DOUT); end
      peek(BASE);
      n_cmp++;
      if (IRQ_DOUT !== 8'h00) begin n_err++; $display("FAIL rst_mask: got %h want 00", IRQ_DOUT); end
   endtask

   task automatic test_basic();
      drive(8'h00, BASE, 8'h08, 1'b1); step();
      drive(8'h08, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT) step();
      n_cmp++;
      if (INTERRUPT !== 1'b0) begin n_err++; $display("FAIL basic_early: got %b want 0", INTERRUPT); end
      step();
      n_cmp++;
      if (INTERRUPT !== 1'b1) begin n_err++; $display("FAIL basic_int: got %b want 1", INTERRUPT); end
      peek(BASE + 8'd2);
      n_cmp++;
      if (IRQ_DOUT !== 8'h03) begin n_err++; $display("FAIL basic_vec: got %h want 03", IRQ_DOUT); end
      drive(8'h00, BASE + 8'd2, 8'h5A, 1'b1); step();
      peek(BASE + 8'd1);
      n_cmp++;
      if (INTERRUPT !== 1'b0 || IRQ_DOUT !== 8'h00) begin
         n_err++; $display("FAIL basic_ack: int %b pend %h want 0 00", INTERRUPT, IRQ_DOUT);
      end
      peek(BASE + 8'd3);
      n_cmp++;
      if (IRQ_DOUT !== 8'h02) begin n_err++; $display("FAIL basic_svc: got %h want 02", IRQ_DOUT); end
      drive(8'h00, BASE + 8'd3, 8'hA5, 1'b1); step();
      peek(BASE + 8'd3);
      n_cmp++;
      if (IRQ_DOUT !== 8'h00) begin n_err++; $display("FAIL basic_eoi: got %h want 00", IRQ_DOUT); end
   endtask

   task automatic test_priority();
      drive(8'h00, BASE, 8'hFF, 1'b1); step();
      drive(8'h44, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 1) step();
      peek(BASE + 8'd2);
      n_cmp++;
      if (INTERRUPT !== 1'b1 || IRQ_DOUT !== 8'h02) begin
         n_err++; $display("FAIL prio_first: int %b vec %h want 1 02", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
      IO_STRB = 1'b0; #1;
      n_cmp++;
      if (INTERRUPT !== 1'b0) begin n_err++; $display("FAIL prio_idle_gap: got %b want 0", INTERRUPT); end
      step();
      peek(BASE + 8'd2);
      n_cmp++;
      if (INTERRUPT !== 1'b1 || IRQ_DOUT !== 8'h06) begin
         n_err++; $display("FAIL prio_second: int %b vec %h want 1 06", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
   endtask

   task automatic test_masking();
      drive(8'h00, BASE, 8'h00, 1'b1); step();
      drive(8'h02, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 3) step();
      peek(BASE + 8'd1);
      n_cmp++;
      if (INTERRUPT !== 1'b0 || IRQ_DOUT !== 8'h02) begin
         n_err++; $display("FAIL mask_hold: int %b pend %h want 0 02", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE, 8'h02, 1'b1); step();
      IO_STRB = 1'b0; #1;
      n_cmp++;
      if (INTERRUPT !== 1'b0) begin n_err++; $display("FAIL mask_wr_edge: got %b want 0", INTERRUPT); end
      step();
      n_cmp++;
      if (INTERRUPT !== 1'b1) begin n_err++; $display("FAIL mask_rise: got %b want 1", INTERRUPT); end
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
   endtask

   task automatic test_collision();
      drive(8'h00, BASE, 8'h10, 1'b1); step();
      drive(8'h10, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 1) step();
      n_cmp++;
      if (INTERRUPT !== 1'b1) begin n_err++; $display("FAIL coll_req: got %b want 1", INTERRUPT); end
      drive(8'h10, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT) step();
      drive(8'h10, BASE + 8'd2, 8'h00, 1'b1); step();
      peek(BASE + 8'd1);
      n_cmp++;
      if (INTERRUPT !== 1'b0 || IRQ_DOUT !== 8'h10) begin
         n_err++; $display("FAIL coll_set_wins: int %b pend %h want 0 10", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
      IO_STRB = 1'b0; step();
      peek(BASE + 8'd2);
      n_cmp++;
      if (INTERRUPT !== 1'b1 || IRQ_DOUT !== 8'h04) begin
         n_err++; $display("FAIL coll_reenter: int %b vec %h want 1 04", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
   endtask

   task automatic test_misuse();
      drive(8'h00, BASE, 8'h01, 1'b1); step();
      drive(8'h01, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 1) step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
      peek(BASE + 8'd3);
      n_cmp++;
      if (INTERRUPT !== 1'b1 || IRQ_DOUT !== 8'h01) begin
         n_err++; $display("FAIL misuse_eoi_req: int %b state %h want 1 01", INTERRUPT, IRQ_DOUT);
      end
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      drive(8'h00, BASE + 8'd3, 8'h00, 1'b1); step();
      drive(8'h00, BASE, 8'h00, 1'b1); step();
      drive(8'h80, 8'h00, 8'h00, 1'b0); step();
      drive(8'h00, 8'h00, 8'h00, 1'b0);
      repeat (SYNC_LAT + 1) step();
      drive(8'h00, BASE + 8'd2, 8'h00, 1'b1); step();
      peek(BASE + 8'd3);
      n_cmp++;
      if (IRQ_DOUT !== 8'h00) begin n_err++; $display("FAIL misuse_ack_idle_state: got %h want 00", IRQ_DOUT); end
      peek(BASE + 8'd1);
      n_cmp++;
      if (IRQ_DOUT !== 8'h80) begin n_err++; $display("FAIL misuse_ack_idle_pend: got %h want 80", IRQ_DOUT); end
      drive(8'h00, BASE + 8'd1, 8'h00, 1'b1); step();
      peek(BASE + 8'd1);
      n_cmp++;
      if (IRQ_DOUT !== 8'h80) begin n_err++; $display("FAIL misuse_ro_write: got %h want 80", IRQ_DOUT); end
      peek(8'hE4);
      n_cmp++;
      if (IRQ_SEL !== 1'b0 || IRQ_DOUT !== 8'h00) begin
         n_err++; $display("FAIL misuse_decode: sel %b dout %h want 0 00", IRQ_SEL, IRQ_DOUT);
      end
   endtask

   task automatic test_random();
      logic [7:0] irq, port, exp;
      logic       strb, exp_sel;
      int         off;
      irq = 8'h00;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) irq = 8'($urandom);
         strb = ($urandom_range(3) == 0);
         port = ($urandom_range(7) == 0) ? 8'($urandom) : BASE + 8'($urandom_range(3));
         drive(irq, port, 8'($urandom), strb);
         #1;
         off     = int'(port) - int'(BASE);
         exp_sel = (off >= 0 && off <= 3);
         exp     = m_read(port);
         n_cmp++;
         if (INTERRUPT !== (m_phase == 1) || IRQ_SEL !== exp_sel || IRQ_DOUT !== exp) begin
            n_err++;
            $display("FAIL rand_c%0d port %h: int %b sel %b dout %h want %b %b %h",
                     c, port, INTERRUPT, IRQ_SEL, IRQ_DOUT, (m_phase == 1), exp_sel, exp);
         end
         step();
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_reset_mid_req();
      test_basic();
      test_priority();
      test_masking();
      test_collision();
      test_misuse();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
